// File: rtl/coherence_bus_arbiter.sv
// Snooping-bus controller for the MSI coherence fabric. It grants one cache
// request at a time in round-robin order, broadcasts it to the other caches,
// collects their snoop replies, and completes the transaction either from
// memory or from the owning cache's write-back data.
module coherence_bus_arbiter #(
  parameter int NCACHE = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NCACHE-1:0]        req_valid,
  input  logic [2*NCACHE-1:0]      req_type,
  input  logic [ADDR_W*NCACHE-1:0] req_addr,
  input  logic [DATA_W*NCACHE-1:0] req_data,
  output logic [NCACHE-1:0]        req_done,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     busy,
  output logic [NCACHE-1:0]        snoop_valid,
  output logic [1:0]               snoop_type,
  output logic [ADDR_W-1:0]        snoop_addr,
  input  logic [NCACHE-1:0]        snoop_writeBack,
  input  logic [NCACHE-1:0]        snoop_abort,
  input  logic [DATA_W*NCACHE-1:0] snoop_data,
  output logic                     mem_wren,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int IDX_W = (NCACHE > 1) ? $clog2(NCACHE) : 1;
  localparam logic [1:0] T_INV = 2'b10;
  localparam logic [1:0] T_WB  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, SNOOP, SNOOP_RSP, WB_MEM, MEM_RD, MEM_WAIT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    req_q, req_d;
  logic [1:0]          type_q, type_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   resp_q, resp_d;

  logic                gnt_found;
  logic [IDX_W-1:0]    gnt_idx;
  int                  cand;
  logic                own_found;
  logic [IDX_W-1:0]    own_idx;

  logic [1:0]          rtype [NCACHE];
  logic [ADDR_W-1:0]   raddr [NCACHE];
  logic [DATA_W-1:0]   rdat  [NCACHE];
  logic [DATA_W-1:0]   sdat  [NCACHE];

  // An abort reply only matters together with a write-back, which already
  // cancels the memory read, so the abort lines carry no extra information.
  logic unused_abort;
  assign unused_abort = ^snoop_abort;

  for (genvar g = 0; g < NCACHE; g++) begin : g_unpack
    assign rtype[g] = req_type[2*g +: 2];
    assign raddr[g] = req_addr[ADDR_W*g +: ADDR_W];
    assign rdat[g]  = req_data[DATA_W*g +: DATA_W];
    assign sdat[g]  = snoop_data[DATA_W*g +: DATA_W];
  end

  // Round-robin pick: first pending cache after the last one granted.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NCACHE; k++) begin
      cand = (int'(last_q) + k) % NCACHE;
      if (!gnt_found && req_valid[IDX_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

  // Lowest-index cache (other than the requester) supplying a Modified copy.
  always_comb begin
    own_found = 1'b0;
    own_idx   = '0;
    for (int i = NCACHE - 1; i >= 0; i--) begin
      if (snoop_writeBack[i] && (IDX_W'(i) != req_q)) begin
        own_found = 1'b1;
        own_idx   = IDX_W'(i);
      end
    end
  end

  // Next-state logic and transaction latching.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    req_d   = req_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_d   = gnt_idx;
          last_d  = gnt_idx;
          type_d  = rtype[gnt_idx];
          addr_d  = raddr[gnt_idx];
          wdata_d = rdat[gnt_idx];
          state_d = (rtype[gnt_idx] == T_WB) ? WB_MEM : SNOOP;
        end
      end
      SNOOP: state_d = SNOOP_RSP;
      SNOOP_RSP: begin
        if (type_q == T_INV) begin
          state_d = DONE;
        end else if (own_found) begin
          resp_d  = sdat[own_idx];
          wdata_d = sdat[own_idx];
          state_d = WB_MEM;
        end else begin
          state_d = MEM_RD;
        end
      end
      WB_MEM:   state_d = DONE;
      MEM_RD:   state_d = MEM_WAIT;
      MEM_WAIT: begin
        resp_d  = mem_rdata;
        state_d = DONE;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Control state and the response register, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NCACHE - 1);
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

  // Latched request fields; only observed through state-gated outputs.
  always_ff @(posedge clock) begin
    type_q  <= type_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Bus, memory and completion outputs decoded from the current state.
  always_comb begin
    busy        = (state_q != IDLE);
    snoop_valid = '0;
    snoop_type  = '0;
    snoop_addr  = '0;
    req_done    = '0;
    mem_wren    = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    resp_data   = resp_q;
    case (state_q)
      SNOOP: begin
        snoop_valid = ~(NCACHE'(1) << req_q);
        snoop_type  = type_q;
        snoop_addr  = addr_q;
      end
      WB_MEM: begin
        mem_wren  = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      MEM_RD:  mem_addr = addr_q;
      DONE:    req_done = NCACHE'(1) << req_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: cache drivers, snoop responders and a
// memory device around the DUT, with a scoreboard fed by a transaction-level
// reference model and drained by an independent monitor.
module tb_coherence_bus_arbiter;

  localparam int NC = 4;
  localparam int AW = 5;
  localparam int DW = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NC-1:0]     req_valid;
  logic [2*NC-1:0]   req_type;
  logic [AW*NC-1:0]  req_addr;
  logic [DW*NC-1:0]  req_data;
  logic [NC-1:0]     req_done;
  logic [DW-1:0]     resp_data;
  logic              busy;
  logic [NC-1:0]     snoop_valid;
  logic [1:0]        snoop_type;
  logic [AW-1:0]     snoop_addr;
  logic [NC-1:0]     snoop_writeBack;
  logic [NC-1:0]     snoop_abort;
  logic [DW*NC-1:0]  snoop_data;
  logic              mem_wren;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  coherence_bus_arbiter #(.NCACHE(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
    .req_done(req_done), .resp_data(resp_data), .busy(busy),
    .snoop_valid(snoop_valid), .snoop_type(snoop_type), .snoop_addr(snoop_addr),
    .snoop_writeBack(snoop_writeBack), .snoop_abort(snoop_abort), .snoop_data(snoop_data),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory device ----------------
  logic [DW-1:0] env_mem [32];
  always @(posedge clock) begin
    if (mem_wren) env_mem[mem_addr] <= mem_wdata;
    mem_rdata <= env_mem[mem_addr];
  end

  // ---------------- snoop responders ----------------
  logic [NC-1:0]    plan_wb [NC];
  logic [NC-1:0]    plan_ab [NC];
  logic [DW*NC-1:0] plan_sd [NC];
  int resp_r;
  always @(negedge clock) begin
    if (!reset && snoop_valid != '0) begin
      resp_r = 0;
      for (int i = 0; i < NC; i++) if (!snoop_valid[i]) resp_r = i;
      @(posedge clock); #1;
      snoop_writeBack = plan_wb[resp_r];
      snoop_abort     = plan_ab[resp_r];
      snoop_data      = plan_sd[resp_r];
      @(posedge clock); #1;
      snoop_writeBack = '0;
      snoop_abort     = '0;
      snoop_data      = '0;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int            req;
    int            lat;
    logic [DW-1:0] resp;
    logic [NC-1:0] snp;
    int            wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } exp_t;
  exp_t sb[$];

  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] ref_resp;
  int            ref_last;

  // Expected outcome of one granted transaction, applied to the model.
  task automatic expect_txn(input int r, input int t, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [NC-1:0] wb,
                            input logic [DW*NC-1:0] sd);
    exp_t e;
    logic [NC-1:0] m;
    int owner;
    e.req = r; e.wr = 0; e.wa = '0; e.wd = '0;
    e.snp = (t == 3) ? '0 : (~(NC'(1) << r));
    if (t == 3) begin
      ref_mem[a] = d; e.wr = 1; e.wa = a; e.wd = d; e.lat = 2;
    end else if (t == 2) begin
      e.lat = 3;
    end else begin
      m = wb & ~(NC'(1) << r);
      if (m != '0) begin
        owner = 0;
        for (int i = NC - 1; i >= 0; i--) if (m[i]) owner = i;
        ref_resp = sd[owner*DW +: DW];
        ref_mem[a] = ref_resp;
        e.wr = 1; e.wa = a; e.wd = ref_resp; e.lat = 4;
      end else begin
        ref_resp = ref_mem[a];
        e.lat = 5;
      end
    end
    e.resp = ref_resp;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int cyc = 0, start = 0, snp_cyc = 0, wr_n = 0, wr_cyc = 0;
  bit active = 0;
  logic [NC-1:0] snp_seen;
  logic [AW-1:0] wr_a;
  logic [DW-1:0] wr_d;
  exp_t me;
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      active = 0;
    end else begin
      if (busy && !active) begin
        active = 1; start = cyc; snp_seen = '0; snp_cyc = -1;
        wr_n = 0; wr_a = '0; wr_d = '0; wr_cyc = -1;
      end
      if (active) begin
        if (snoop_valid != '0) begin snp_seen = snoop_valid; snp_cyc = cyc - start + 1; end
        if (mem_wren) begin wr_n++; wr_a = mem_addr; wr_d = mem_wdata; wr_cyc = cyc - start + 1; end
      end
      if (req_done != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(req_done), 32'd0);
        end else begin
          me = sb.pop_front();
          chk("done_vec", 32'(req_done), 32'(NC'(1) << me.req));
          chk("resp_data", 32'(resp_data), 32'(me.resp));
          chk("latency", 32'(cyc - start + 1), 32'(me.lat));
          chk("snoop_vec", 32'(snp_seen), 32'(me.snp));
          if (me.snp != '0) chk("snoop_cycle", 32'(snp_cyc), 32'd1);
          chk("mem_writes", 32'(wr_n), 32'(me.wr));
          if (me.wr != 0) begin
            chk("mem_waddr", 32'(wr_a), 32'(me.wa));
            chk("mem_wdata", 32'(wr_d), 32'(me.wd));
            chk("mem_wcycle", 32'(wr_cyc), 32'(me.lat - 1));
          end
        end
        active = 0;
      end
    end
  end

  // ---------------- cache driver ----------------
  task automatic issue(input int c, input int t, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [NC-1:0] wb, input logic [NC-1:0] ab, input logic [DW*NC-1:0] sd);
    int n;
    plan_wb[c] = wb; plan_ab[c] = ab; plan_sd[c] = sd;
    req_type[2*c +: 2]  = t[1:0];
    req_addr[AW*c +: AW] = a;
    req_data[DW*c +: DW] = d;
    req_valid[c] = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!req_done[c] && n < 80);
    if (!req_done[c]) chk("done_timeout", 32'(c), 32'hFFFF);
    @(posedge clock); #1;
    req_valid[c] = 1'b0;
  endtask

  // ---------------- batch helpers ----------------
  int               b_t [NC], b2_t [NC];
  logic [AW-1:0]    b_a [NC], b2_a [NC];
  logic [DW-1:0]    b_d [NC], b2_d [NC];
  logic [NC-1:0]    b_wb [NC], b2_wb [NC], b_ab [NC], b2_ab [NC];
  logic [DW*NC-1:0] b_sd [NC], b2_sd [NC];

  // Predicted round-robin service order for a set of simultaneous requests;
  // caches in readd re-request once right after their first completion.
  task automatic predict(input logic [NC-1:0] mask, input logic [NC-1:0] readd);
    logic [NC-1:0] pend, seen;
    int last, pick, cc;
    pend = mask; seen = '0; last = ref_last;
    while (pend != '0) begin
      pick = -1;
      for (int k = 1; k <= NC; k++) begin
        cc = (last + k) % NC;
        if (pick < 0 && pend[cc]) pick = cc;
      end
      pend[pick] = 1'b0;
      last = pick;
      if (!seen[pick]) begin
        seen[pick] = 1'b1;
        expect_txn(pick, b_t[pick], b_a[pick], b_d[pick], b_wb[pick], b_sd[pick]);
        if (readd[pick]) pend[pick] = 1'b1;
      end else begin
        expect_txn(pick, b2_t[pick], b2_a[pick], b2_d[pick], b2_wb[pick], b2_sd[pick]);
      end
    end
    ref_last = last;
  endtask

  task automatic run_batch(input logic [NC-1:0] mask, input logic [NC-1:0] readd);
    predict(mask, readd);
    fork
      begin if (mask[0]) begin issue(0, b_t[0], b_a[0], b_d[0], b_wb[0], b_ab[0], b_sd[0]);
        if (readd[0]) issue(0, b2_t[0], b2_a[0], b2_d[0], b2_wb[0], b2_ab[0], b2_sd[0]); end end
      begin if (mask[1]) begin issue(1, b_t[1], b_a[1], b_d[1], b_wb[1], b_ab[1], b_sd[1]);
        if (readd[1]) issue(1, b2_t[1], b2_a[1], b2_d[1], b2_wb[1], b2_ab[1], b2_sd[1]); end end
      begin if (mask[2]) begin issue(2, b_t[2], b_a[2], b_d[2], b_wb[2], b_ab[2], b_sd[2]);
        if (readd[2]) issue(2, b2_t[2], b2_a[2], b2_d[2], b2_wb[2], b2_ab[2], b2_sd[2]); end end
      begin if (mask[3]) begin issue(3, b_t[3], b_a[3], b_d[3], b_wb[3], b_ab[3], b_sd[3]);
        if (readd[3]) issue(3, b2_t[3], b2_a[3], b2_d[3], b2_wb[3], b2_ab[3], b2_sd[3]); end end
    join
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_snoop", 32'({snoop_valid, snoop_type, snoop_addr}), 32'd0);
    chk("rst_mem", 32'({mem_wren, mem_addr, mem_wdata}), 32'd0);
    chk("rst_resp", 32'(resp_data), 32'd0);
    reset = 1'b0;
    ref_last = NC - 1;
    ref_resp = '0;
  endtask

  int n;
  int rc, rt;
  logic [NC-1:0] rmask;

  initial begin
    reset = 1'b1;
    req_valid = '0; req_type = '0; req_addr = '0; req_data = '0;
    snoop_writeBack = '0; snoop_abort = '0; snoop_data = '0;
    for (int i = 0; i < NC; i++) begin plan_wb[i] = '0; plan_ab[i] = '0; plan_sd[i] = '0; end
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = DW'($urandom);
      env_mem[i] = ref_mem[i];
    end
    ref_mem[5'h0A] = 8'h5C; env_mem[5'h0A] = 8'h5C;
    @(posedge clock); #1;
    do_reset();

    // Directed single transactions.
    expect_txn(2, 0, 5'h0A, 8'h00, 4'b0000, 32'h0);
    issue(2, 0, 5'h0A, 8'h00, 4'b0000, 4'b0000, 32'h0);
    expect_txn(0, 1, 5'h03, 8'h00, 4'b1000, 32'hA7000000);
    issue(0, 1, 5'h03, 8'h00, 4'b1000, 4'b1000, 32'hA7000000);
    expect_txn(1, 2, 5'h11, 8'h00, 4'b0000, 32'h0);
    issue(1, 2, 5'h11, 8'h00, 4'b0000, 4'b0000, 32'h0);
    expect_txn(3, 3, 5'h1F, 8'h42, 4'b0000, 32'h0);
    issue(3, 3, 5'h1F, 8'h42, 4'b0000, 4'b0000, 32'h0);
    ref_last = 3;

    // All four request together after reset; cache 1 re-requests at once.
    do_reset();
    b_t[0] = 0; b_a[0] = 5'h01; b_d[0] = 8'h00; b_wb[0] = '0;     b_ab[0] = '0;     b_sd[0] = '0;
    b_t[1] = 1; b_a[1] = 5'h02; b_d[1] = 8'h00; b_wb[1] = 4'b1000; b_ab[1] = 4'b0100; b_sd[1] = 32'h3C000000;
    b_t[2] = 2; b_a[2] = 5'h07; b_d[2] = 8'h00; b_wb[2] = '0;     b_ab[2] = '0;     b_sd[2] = '0;
    b_t[3] = 3; b_a[3] = 5'h04; b_d[3] = 8'h9E; b_wb[3] = '0;     b_ab[3] = '0;     b_sd[3] = '0;
    b2_t[1] = 0; b2_a[1] = 5'h04; b2_d[1] = 8'h00; b2_wb[1] = 4'b0010; b2_ab[1] = 4'b0001; b2_sd[1] = 32'h000000EE;
    run_batch(4'b1111, 4'b0010);

    // Reset during SNOOP_RSP of a writeMiss with an owner write-back.
    @(posedge clock); #1;
    plan_wb[0] = 4'b1000; plan_ab[0] = 4'b0000; plan_sd[0] = 32'h77000000;
    req_type[1:0] = 2'b01; req_addr[AW-1:0] = 5'h05; req_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (snoop_valid == '0 && n < 20);
    chk("midrst_snoop_seen", 32'(snoop_valid), 32'b1110);
    @(posedge clock); #1;
    reset = 1'b1; req_valid[0] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    ref_last = NC - 1; ref_resp = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("midrst_quiet", 32'({busy, mem_wren, req_done}), 32'd0);
    end

    // Randomized single transactions.
    for (int it = 0; it < 40; it++) begin
      rc = $urandom_range(0, NC - 1);
      rt = $urandom_range(0, 3);
      b_a[0] = AW'($urandom); b_d[0] = DW'($urandom);
      b_wb[0] = ($urandom_range(0, 2) == 0) ? NC'($urandom_range(1, 15)) : '0;
      b_ab[0] = NC'($urandom); b_sd[0] = $urandom;
      expect_txn(rc, rt, b_a[0], b_d[0], b_wb[0], b_sd[0]);
      ref_last = rc;
      issue(rc, rt, b_a[0], b_d[0], b_wb[0], b_ab[0], b_sd[0]);
    end

    // Randomized concurrent batches.
    for (int it = 0; it < 8; it++) begin
      rmask = NC'($urandom_range(1, 15));
      for (int c = 0; c < NC; c++) begin
        b_t[c] = $urandom_range(0, 3); b_a[c] = AW'($urandom); b_d[c] = DW'($urandom);
        b_wb[c] = ($urandom_range(0, 1) == 0) ? NC'($urandom) : '0;
        b_ab[c] = NC'($urandom); b_sd[c] = $urandom;
      end
      @(posedge clock); #1;
      run_batch(rmask, 4'b0000);
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clock); n++; end
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
